// File: rtl/md_pkg.sv
// Opcode constants, request payload and FSM state shared by the multiply/divide issue
// stage and the multiply/divide unit.
package md_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned DATA_W = 32;

   localparam logic [OP_W-1:0] NONE  = OP_W'(0);
   localparam logic [OP_W-1:0] MULT  = OP_W'(1);
   localparam logic [OP_W-1:0] MULTU = OP_W'(2);
   localparam logic [OP_W-1:0] DIV   = OP_W'(3);
   localparam logic [OP_W-1:0] DIVU  = OP_W'(4);
   localparam logic [OP_W-1:0] MFHI  = OP_W'(5);
   localparam logic [OP_W-1:0] MFLO  = OP_W'(6);
   localparam logic [OP_W-1:0] MTHI  = OP_W'(7);
   localparam logic [OP_W-1:0] MTLO  = OP_W'(8);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} md_state_t;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } md_req_t;

   function automatic logic is_div(input logic [OP_W-1:0] op);
      return (op == DIV) || (op == DIVU);
   endfunction

   // Ops that occupy the unit and therefore need a start pulse.
   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return (op == MULT) || (op == MULTU) || is_div(op);
   endfunction

endpackage

// File: rtl/md_skid.sv
// One-entry skid register holding a request accepted while the issue stage cannot take it.
module md_skid
   import md_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  logic    pop,
   input  logic    clear,
   input  md_req_t in_req,
   output md_req_t out_req,
   output logic    empty
);

   logic full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full    <= 1'b0;
         out_req <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (push) begin
         full    <= 1'b1;
         out_req <= in_req;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

   assign empty = !full;

endmodule

// File: rtl/md_issue.sv
// Issue stage for multiply/divide-class requests: registers the request, pulses the unit's
// start, squashes divide-by-zero and waits out busy. MD_ISSUE_SKID_EN adds a one-entry skid.
module md_issue
   import md_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              in_ready,
   input  logic              flush,
   input  logic              md_busy,
   output logic              md_start,
   output logic [OP_W-1:0]   md_op,
   output logic [DATA_W-1:0] md_src_a,
   output logic [DATA_W-1:0] md_src_b,
   output logic              stall,
   output logic              dz_err
);

   md_state_t state;
   logic      first_wait;
   logic      eligible;
   logic      accept;
   logic      issue_valid;
   md_req_t   req_in;
   md_req_t   issue_req;

   assign req_in   = '{op: in_op, a: in_a, b: in_b};
   assign eligible = (state == IDLE) && !md_busy;

`ifdef MD_ISSUE_SKID_EN
   logic    skid_empty;
   logic    take_skid;
   md_req_t skid_req;

   // A held request has priority; flush discards both the held and the offered request.
   assign in_ready    = skid_empty;
   assign accept      = in_valid && in_ready && !flush;
   assign take_skid   = !skid_empty && eligible && !flush;
   assign issue_valid = take_skid || (accept && eligible);
   assign issue_req   = take_skid ? skid_req : req_in;

   md_skid u_skid (
      .clk     (clk),
      .reset   (reset),
      .push    (accept && !eligible),
      .pop     (take_skid),
      .clear   (flush),
      .in_req  (req_in),
      .out_req (skid_req),
      .empty   (skid_empty)
   );
`else
   assign in_ready    = eligible;
   assign accept      = in_valid && in_ready && !flush;
   assign issue_valid = accept;
   assign issue_req   = req_in;
`endif

   assign stall = in_valid && !in_ready;

   // md_start doubles as the "went to the unit" flag while in ISSUE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         first_wait <= 1'b0;
         md_start   <= 1'b0;
         md_op      <= NONE;
         md_src_a   <= '0;
         md_src_b   <= '0;
         dz_err     <= 1'b0;
      end else begin
         md_start <= 1'b0;
         md_op    <= NONE;
         dz_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (issue_valid) begin
                  state    <= ISSUE;
                  md_op    <= issue_req.op;
                  md_src_a <= issue_req.a;
                  md_src_b <= issue_req.b;
                  md_start <= is_muldiv(issue_req.op) &&
                              !(is_div(issue_req.op) && (issue_req.b == '0));
                  dz_err   <= is_div(issue_req.op) && (issue_req.b == '0);
               end
            end
            ISSUE: begin
               if (md_start) begin
                  state      <= WAIT;
                  first_wait <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               // Busy lags start by a cycle, so the first WAIT cycle cannot trust it.
               if (first_wait) begin
                  first_wait <= 1'b0;
               end else if (!md_busy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/md_issue.md
MD_ISSUE -- requirements
Module: md_issue

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1: the ID stage presents a multiply/divide-class request.
REQ-004 SHALL have port in_op, input, 4: request opcode, encoded per md_pkg.
REQ-005 SHALL have ports in_a and in_b, input, 32 each: forwarded rs and rt operands.
REQ-006 SHALL have port in_ready, output, 1: the request is accepted on a cycle where in_valid and in_ready are both high.
REQ-007 SHALL have port flush, input, 1: discard every request not yet issued.
REQ-008 SHALL have port md_busy, input, 1: busy output of the downstream multiply/divide unit.
REQ-009 SHALL have port md_start, output, 1: one-cycle start pulse to the unit.
REQ-010 SHALL have port md_op, output, 4, and ports md_src_a and md_src_b, output, 32 each: registered operation and operands driven to the unit.
REQ-011 SHALL have port stall, output, 1, equal to in_valid AND NOT in_ready.
REQ-012 SHALL have port dz_err, output, 1: one-cycle pulse when a divide with a zero divisor is squashed.

Function
REQ-013 SHALL implement an FSM with states IDLE, ISSUE and WAIT.
REQ-014 On accept in IDLE, SHALL register op, a and b, and enter ISSUE on the next edge; md_op, md_src_a and md_src_b are valid throughout ISSUE.
REQ-015 In ISSUE, SHALL drive md_start=1 for exactly one cycle if op is MULT, MULTU, DIV or DIVU, then go to WAIT.
REQ-016 In ISSUE with a move op (MFHI, MFLO, MTHI, MTLO), SHALL keep md_start=0 and return to IDLE after one cycle.
REQ-017 In WAIT, SHALL ignore md_busy during the first WAIT cycle, since busy rises one cycle after start.
REQ-018 In WAIT, SHALL return to IDLE on the first later cycle with md_busy=0.
REQ-019 in_ready SHALL be 1 only in IDLE with md_busy=0 (non-skid build).
REQ-020 A DIV or DIVU request with in_b==0 SHALL be accepted, SHALL never raise md_start, SHALL pulse dz_err in its ISSUE cycle, and SHALL return to IDLE, leaving HI/LO unchanged.
REQ-021 With op NONE or an undefined code, the block SHALL accept the request and return to IDLE with no start pulse and no dz_err.
REQ-022 flush with a simultaneous accept: flush SHALL win and the request SHALL be dropped.
REQ-023 flush in ISSUE or WAIT SHALL NOT abort an already-issued start; the FSM SHALL complete normally.
REQ-024 Outside ISSUE, md_op SHALL read NONE, md_start SHALL read 0, and the operand registers SHALL hold their last values.

Reset
REQ-025 While reset is high, the block SHALL immediately force state IDLE, md_start=0, md_op=NONE, md_src_a=md_src_b=0, dz_err=0 and an empty skid buffer.
REQ-026 Reset during ISSUE or WAIT SHALL abandon the operation, and the block SHALL be ready on the first edge after reset deasserts with md_busy=0.

Configuration
REQ-027 Macro MD_ISSUE_SKID_EN defined: the block SHALL add a one-entry skid register, and in_ready SHALL equal "skid empty", a registered value independent of md_busy and state.
REQ-028 With MD_ISSUE_SKID_EN, a request accepted while not IDLE or while md_busy=1 SHALL be held in skid and issued on the first eligible IDLE cycle; flush SHALL clear skid.
REQ-029 Macro MD_ISSUE_SKID_EN undefined: the block SHALL have no skid storage, and in_ready SHALL follow REQ-019.

Structure
REQ-030 Package md_pkg SHALL hold the opcode constants NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, and the FSM state typedef; it is shared with the multiply/divide unit.
REQ-031 The skid buffer SHALL be sub-module md_skid, instantiated only under MD_ISSUE_SKID_EN; the rest of the block SHALL be flat.

Verification
REQ-032 MULT a=3, b=-2 accepted at edge N, unit mocked with 5 busy cycles -> md_start high only in cycle N+1, in_ready low until busy drops, then high.
REQ-033 DIVU a=7, b=0 -> dz_err pulses once, md_start stays 0, in_ready returns the following cycle.
REQ-034 MTHI a=0x1234 -> md_op=MTHI for one cycle, md_start=0, no WAIT state visited.
REQ-035 Back-to-back MULT then MFLO with in_valid held -> stall high during WAIT, MFLO issued on the first cycle after md_busy falls.
REQ-036 flush in the same cycle as accept of DIV -> no start pulse; a flush during WAIT -> start already issued and the FSM completes.
REQ-037 MD_ISSUE_SKID_EN build: second MULT offered while busy -> accepted into skid, issued after busy falls; reset asserted in WAIT -> all outputs at reset values immediately.
